// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, mode constants
// and a counter-width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam logic CPHA_LEAD = 1'b0;
    localparam logic CPHA_TRAIL = 1'b1;
    localparam logic ORDER_MSB = 1'b0;
    localparam logic ORDER_LSB = 1'b1;

    // Bits needed for a counter that takes n distinct values (0..n-1).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK timing: a half-period counter plus an edge counter that flags
// leading/trailing SCLK edges while the master is shifting.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned N_EDGES = 16
) (
    input  logic clka,
    input  logic reset,
    input  logic run,
    input  logic shift,
    output logic tick_c,
    output logic lead_c,
    output logic trail_c,
    output logic first_c,
    output logic last_c
);

    localparam int unsigned DIV_W  = cnt_w(CLK_DIV);
    localparam int unsigned EDGE_W = cnt_w(N_EDGES);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    // tick marks the last clka cycle of each half-period.
    always_comb begin
        tick_c  = (div_q == DIV_W'(CLK_DIV - 1));
        first_c = (edge_q == '0);
        last_c  = (edge_q == EDGE_W'(N_EDGES - 1));
        lead_c  = shift && tick_c && !edge_q[0];
        trail_c = shift && tick_c && edge_q[0];

        div_d  = div_q;
        edge_d = edge_q;
        if (!run || tick_c) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        if (!shift) begin
            edge_d = '0;
        end else if (tick_c && !last_c) begin
            edge_d = edge_q + EDGE_W'(1);
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_p.sv
// Single-frame SPI master with configurable frame length, clock divider,
// SPI mode and bit order; all outputs come straight from flops.
module spi_master_p
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          CPOL      = 1'b0,
    parameter bit          CPHA      = 1'b0,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n,
    output logic              busy
);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;
    logic              tx_ready_q;
    logic              busy_q;
    logic              sample, advance;

    logic tick_c, lead_c, trail_c, first_c, last_c;

    spi_clkgen #(
        .CLK_DIV (CLK_DIV),
        .N_EDGES (2 * DATA_W)
    ) u_clkgen (
        .clka    (clka),
        .reset   (reset),
        .run     (state_q != ST_IDLE),
        .shift   (state_q == ST_SHIFT),
        .tick_c  (tick_c),
        .lead_c  (lead_c),
        .trail_c (trail_c),
        .first_c (first_c),
        .last_c  (last_c)
    );

    function automatic logic head_bit(input logic [DATA_W-1:0] v);
        return (LSB_FIRST == ORDER_LSB) ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] v);
        return (LSB_FIRST == ORDER_LSB) ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
    endfunction

    // Received bits enter from the far end so the first bit lands where it was sent from.
    function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] v, input logic b);
        return (LSB_FIRST == ORDER_LSB) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = CPOL;
        mosi_d     = 1'b0;
        cs_n_d     = 1'b1;
        sample     = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_SETUP;
                    tx_sh_d = tx_data;
                    rx_sh_d = '0;
                    mosi_d  = head_bit(tx_data);
                    cs_n_d  = 1'b0;
                end
            end
            ST_SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = mosi_q;
                if (tick_c) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cs_n_d = 1'b0;
                mosi_d = mosi_q;
                sclk_d = (lead_c || trail_c) ? ~sclk_q : sclk_q;
                if (CPHA == CPHA_LEAD) begin
                    sample  = lead_c;
                    advance = trail_c && !last_c;
                end else begin
                    sample  = trail_c;
                    advance = lead_c && !first_c;
                end
                if (trail_c && last_c) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cs_n_d = 1'b0;
                mosi_d = mosi_q;
                if (tick_c) begin
                    state_d    = ST_GAP;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    cs_n_d     = 1'b1;
                    mosi_d     = 1'b0;
                end
            end
            ST_GAP: begin
                if (tick_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (sample) begin
            rx_sh_d = rx_ins(rx_sh_q, miso);
        end
        if (advance) begin
            tx_sh_d = tx_adv(tx_sh_q);
            mosi_d  = head_bit(tx_adv(tx_sh_q));
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= CPOL;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_spi_master_p.sv
// Directed bench for spi_master_p: mode 0 loopback, mode 3 MSB-first,
// back-to-back frames, mid-frame reset and a 3-bit / divide-by-1 frame.
module tb_spi_master_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic clr = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    // DUT 0: 8 bits, div 2, mode 0, LSB first, miso looped back
    logic       tv0 = 1'b0;
    logic [7:0] td0 = '0;
    logic       tr0, rv0, sclk0, mosi0, cs0_n, busy0;
    logic [7:0] rd0;

    spi_master_p #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_dut0 (
        .clka(clk), .reset(rst), .tx_valid(tv0), .tx_data(td0), .tx_ready(tr0),
        .rx_valid(rv0), .rx_data(rd0), .sclk(sclk0), .mosi(mosi0), .miso(mosi0),
        .cs_n(cs0_n), .busy(busy0)
    );

    // DUT 3: 8 bits, div 2, mode 3, MSB first, miso from a bench slave
    logic       tv3 = 1'b0;
    logic [7:0] td3 = '0;
    logic       tr3, rv3, sclk3, mosi3, cs3_n, busy3;
    logic [7:0] rd3;
    logic       miso3 = 1'b0;

    spi_master_p #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b0)) u_dut3 (
        .clka(clk), .reset(rst), .tx_valid(tv3), .tx_data(td3), .tx_ready(tr3),
        .rx_valid(rv3), .rx_data(rd3), .sclk(sclk3), .mosi(mosi3), .miso(miso3),
        .cs_n(cs3_n), .busy(busy3)
    );

    // DUT 1: 3 bits, div 1, mode 0, LSB first, miso looped back
    logic       tv1 = 1'b0;
    logic [2:0] td1 = '0;
    logic       tr1, rv1, sclk1, mosi1, cs1_n, busy1;
    logic [2:0] rd1;

    spi_master_p #(.DATA_W(3), .CLK_DIV(1), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b1)) u_dut1 (
        .clka(clk), .reset(rst), .tx_valid(tv1), .tx_data(td1), .tx_ready(tr1),
        .rx_valid(rv1), .rx_data(rd1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1),
        .cs_n(cs1_n), .busy(busy1)
    );

    // Monitor 0: records mosi on rising (sampling) edges, cs_n timing, pulses.
    int         low0, rxc0, nb0, edges0, hi0, gap0, viol0;
    logic       seen0;
    logic       prev0 = 1'b0;
    logic [7:0] bits0;
    always @(negedge clk) begin
        if (clr) begin
            low0 = 0; rxc0 = 0; nb0 = 0; edges0 = 0; hi0 = 0; gap0 = 0; viol0 = 0;
            seen0 = 1'b0; bits0 = '0;
        end else begin
            if (busy0 && tr0) viol0++;
            if (rv0) rxc0++;
            if (cs0_n) begin
                hi0++;
            end else begin
                low0++;
                if (hi0 > 0 && seen0) gap0 = hi0;
                hi0 = 0;
                seen0 = 1'b1;
            end
            if (sclk0 !== prev0) begin
                edges0++;
                if (sclk0 && nb0 < 8) begin
                    bits0[nb0] = mosi0;
                    nb0++;
                end
            end
        end
        prev0 = sclk0;
    end

    // Monitor/slave 3: drives miso MSB-first on falling (leading) edges,
    // records mosi on rising (trailing, sampling) edges.
    int         low3, rxc3, nb3, s3_idx;
    logic       prev3 = 1'b1;
    logic [7:0] bits3;
    logic [7:0] s3_data = '0;
    always @(negedge clk) begin
        if (clr) begin
            low3 = 0; rxc3 = 0; nb3 = 0; s3_idx = 0; bits3 = '0;
        end else begin
            if (rv3) rxc3++;
            if (!cs3_n) low3++;
            if (sclk3 !== prev3) begin
                if (sclk3 && nb3 < 8) begin
                    bits3[nb3] = mosi3;
                    nb3++;
                end else if (!sclk3 && s3_idx < 8) begin
                    miso3 = s3_data[7 - s3_idx];
                    s3_idx++;
                end
            end
        end
        prev3 = sclk3;
    end

    // Monitor 1
    int         low1, rxc1, nb1;
    logic       prev1 = 1'b0;
    logic [2:0] bits1;
    always @(negedge clk) begin
        if (clr) begin
            low1 = 0; rxc1 = 0; nb1 = 0; bits1 = '0;
        end else begin
            if (rv1) rxc1++;
            if (!cs1_n) low1++;
            if (sclk1 !== prev1 && sclk1 && nb1 < 3) begin
                bits1[nb1] = mosi1;
                nb1++;
            end
        end
        prev1 = sclk1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_not_busy(input int k, input string tag);
        int   t = 0;
        logic b;
        while (t < 300) begin
            b = (k == 0) ? busy0 : (k == 1) ? busy1 : busy3;
            if (b === 1'b0) break;
            step(1);
            t++;
        end
        chk(tag, 32'(t < 300), 32'd1);
    endtask

    task automatic clear_mon();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        int t;

        // Reset values, seen on the first cycle after reset
        step(3);
        rst = 1'b0;
        chk("rst_cs_n", 32'(cs0_n), 32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd0);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_rx_valid", 32'(rv0), 32'd0);
        chk("rst_rx_data", 32'(rd0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_tx_ready", 32'(tr0), 32'd1);
        chk("rst_sclk_cpol1", 32'(sclk3), 32'd1);

        // Mode 0 loopback, 0xA5
        clear_mon();
        tv0 = 1'b1; td0 = 8'hA5;
        step(1);
        tv0 = 1'b0;
        chk("A_busy", 32'(busy0), 32'd1);
        chk("A_ready", 32'(tr0), 32'd0);
        chk("A_cs_n", 32'(cs0_n), 32'd0);
        chk("A_first_mosi", 32'(mosi0), 32'd1);
        wait_not_busy(0, "A_timeout");
        step(2);
        chk("A_mosi_bits", 32'(bits0), 32'h0000_00A5);
        chk("A_nbits", 32'(nb0), 32'd8);
        chk("A_cs_low", 32'(low0), 32'd36);
        chk("A_rx_pulses", 32'(rxc0), 32'd1);
        chk("A_rx_data", 32'(rd0), 32'h0000_00A5);

        // Mode 3, MSB first: tx 0xC3, slave sends 0x3C
        clear_mon();
        chk("B_sclk_idle", 32'(sclk3), 32'd1);
        s3_data = 8'h3C;
        tv3 = 1'b1; td3 = 8'hC3;
        step(1);
        tv3 = 1'b0;
        wait_not_busy(3, "B_timeout");
        step(2);
        chk("B_mosi_bits", 32'(bits3), 32'h0000_00C3);
        chk("B_rx_data", 32'(rd3), 32'h0000_003C);
        chk("B_cs_low", 32'(low3), 32'd36);
        chk("B_rx_pulses", 32'(rxc3), 32'd1);
        chk("B_sclk_end", 32'(sclk3), 32'd1);

        // Mode 3 asymmetric pattern: 0x12 sent MSB first is captured as 0x48
        clear_mon();
        s3_data = 8'h35;
        tv3 = 1'b1; td3 = 8'h12;
        step(1);
        tv3 = 1'b0;
        wait_not_busy(3, "B2_timeout");
        step(2);
        chk("B2_mosi_bits", 32'(bits3), 32'h0000_0048);
        chk("B2_rx_data", 32'(rd3), 32'h0000_0035);

        // tx_valid held across two frames
        clear_mon();
        td0 = 8'h5A; tv0 = 1'b1;
        t = 0;
        while (rxc0 < 2 && t < 400) begin
            step(1);
            t++;
        end
        tv0 = 1'b0;
        chk("C_timeout", 32'(t < 400), 32'd1);
        wait_not_busy(0, "C_idle_timeout");
        step(2);
        chk("C_rx_pulses", 32'(rxc0), 32'd2);
        chk("C_gap", 32'(gap0), 32'd3);
        chk("C_ready_while_busy", 32'(viol0), 32'd0);
        chk("C_cs_low", 32'(low0), 32'd72);
        chk("C_rx_data", 32'(rd0), 32'h0000_005A);

        // Reset at the 5th SCLK edge of a frame
        clear_mon();
        td0 = 8'hFF; tv0 = 1'b1;
        step(1);
        tv0 = 1'b0;
        t = 0;
        while (edges0 < 5 && t < 100) begin
            step(1);
            t++;
        end
        chk("D_timeout", 32'(t < 100), 32'd1);
        rst = 1'b1;
        step(1);
        chk("D_cs_n", 32'(cs0_n), 32'd1);
        chk("D_sclk", 32'(sclk0), 32'd0);
        chk("D_mosi", 32'(mosi0), 32'd0);
        chk("D_busy", 32'(busy0), 32'd0);
        chk("D_ready", 32'(tr0), 32'd1);
        rst = 1'b0;
        step(20);
        chk("D_no_rx_valid", 32'(rxc0), 32'd0);
        chk("D_rx_data", 32'(rd0), 32'd0);
        clear_mon();
        td0 = 8'h3C; tv0 = 1'b1;
        step(1);
        tv0 = 1'b0;
        wait_not_busy(0, "D2_timeout");
        step(2);
        chk("D2_mosi_bits", 32'(bits0), 32'h0000_003C);
        chk("D2_rx_data", 32'(rd0), 32'h0000_003C);
        chk("D2_rx_pulses", 32'(rxc0), 32'd1);
        chk("D2_cs_low", 32'(low0), 32'd36);

        // 3-bit frame, divide by 1: 3'b110 -> mosi 0,1,1
        clear_mon();
        td1 = 3'b110; tv1 = 1'b1;
        step(1);
        tv1 = 1'b0;
        chk("E_first_mosi", 32'(mosi1), 32'd0);
        wait_not_busy(1, "E_timeout");
        step(2);
        chk("E_mosi_bits", 32'(bits1), 32'd6);
        chk("E_nbits", 32'(nb1), 32'd3);
        chk("E_cs_low", 32'(low1), 32'd8);
        chk("E_rx_pulses", 32'(rxc1), 32'd1);
        chk("E_rx_data", 32'(rd1), 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
